// File: rtl/bp_be_fe_cmd_arbiter.sv
// BE->FE command arbiter: commit > mispredict > attaboy FIFO, with fence sequencing.
// Optional BP_BE_FE_CMD_ARB_STATS_EN enables the dropped-attaboy counter.
module bp_be_fe_cmd_arbiter #(
  parameter int cmd_width_p        = 64,
  parameter int attaboy_fifo_els_p = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   commit_v_i,
  input  logic [cmd_width_p-1:0] commit_cmd_i,
  input  logic                   spec_v_i,
  input  logic                   spec_attaboy_i,
  input  logic [cmd_width_p-1:0] spec_cmd_i,
  output logic                   spec_ready_o,
  output logic [cmd_width_p-1:0] cmd_o,
  output logic                   cmd_v_o,
  input  logic                   cmd_yumi_i,
  input  logic                   fence_done_i,
  output logic                   fenced_o,
  output logic                   overflow_o,
  output logic [15:0]            attaboy_drops_o
);

  localparam int ptr_w_lp = $clog2(attaboy_fifo_els_p);
  localparam int cnt_w_lp = ptr_w_lp + 1;
  localparam logic [cnt_w_lp-1:0] full_lp =
    cnt_w_lp'(attaboy_fifo_els_p);

  typedef enum logic {e_run, e_fence} state_e;

  state_e state_r, state_n;
  logic run;

  logic                   commit_v_r;
  logic [cmd_width_p-1:0] commit_cmd_r;
  logic                   mis_v_r;
  logic [cmd_width_p-1:0] mis_cmd_r;

  logic [cmd_width_p-1:0] mem_r [attaboy_fifo_els_p];
  logic [ptr_w_lp-1:0]    rptr_r, wptr_r;
  logic [cnt_w_lp-1:0]    cnt_r;

  logic sel_commit, sel_mis, sel_fifo;
  logic fifo_full, spec_acc, mis_acc, ab_acc;
  logic pop, push, flush, ovf_set;

  // FIFO head is only visible in e_run
  assign sel_commit = commit_v_r;
  assign sel_mis    = ~commit_v_r & mis_v_r & run;
  assign sel_fifo   = ~commit_v_r & ~mis_v_r & run
                    & (cnt_r != '0);

  assign cmd_v_o = sel_commit | sel_mis | sel_fifo;

  always_comb begin
    cmd_o = mem_r[rptr_r];
    unique case (1'b1)
      sel_commit: cmd_o = commit_cmd_r;
      sel_mis:    cmd_o = mis_cmd_r;
      default:    cmd_o = mem_r[rptr_r];
    endcase
  end

  assign spec_ready_o = reset_n_i & run & ~commit_v_i
                      & ~commit_v_r & ~mis_v_r;

  assign fifo_full = (cnt_r == full_lp);
  assign spec_acc  = spec_v_i & spec_ready_o;
  assign mis_acc   = spec_acc & ~spec_attaboy_i;
  assign ab_acc    = spec_acc & spec_attaboy_i;
  assign pop       = cmd_yumi_i & sel_fifo;
  assign push      = ab_acc & (~fifo_full | pop);
  assign flush     = commit_v_i | mis_acc;
  assign ovf_set   = commit_v_i & commit_v_r
                   & ~(cmd_yumi_i & sel_commit);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      commit_v_r   <= 1'b0;
      commit_cmd_r <= '0;
      overflow_o   <= 1'b0;
    end else begin
      if (commit_v_i) begin
        commit_v_r   <= 1'b1;
        commit_cmd_r <= commit_cmd_i;
      end else if (cmd_yumi_i & sel_commit) begin
        commit_v_r <= 1'b0;
      end
      if (ovf_set) overflow_o <= 1'b1;
    end
  end

  // A commit squashes any pending mispredict
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mis_v_r   <= 1'b0;
      mis_cmd_r <= '0;
    end else begin
      if (commit_v_i) begin
        mis_v_r <= 1'b0;
      end else if (mis_acc) begin
        mis_v_r   <= 1'b1;
        mis_cmd_r <= spec_cmd_i;
      end else if (cmd_yumi_i & sel_mis) begin
        mis_v_r <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rptr_r <= '0;
      wptr_r <= '0;
      cnt_r  <= '0;
    end else if (flush) begin
      rptr_r <= '0;
      wptr_r <= '0;
      cnt_r  <= '0;
    end else begin
      if (pop)  rptr_r <= rptr_r + ptr_w_lp'(1);
      if (push) wptr_r <= wptr_r + ptr_w_lp'(1);
      if (push & ~pop) cnt_r <= cnt_r + cnt_w_lp'(1);
      if (pop & ~push) cnt_r <= cnt_r - cnt_w_lp'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < attaboy_fifo_els_p; i++)
        mem_r[i] <= '0;
    end else if (push) begin
      mem_r[wptr_r] <= spec_cmd_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= e_run;
    else            state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    unique case (state_r)
      e_run:
        if (cmd_yumi_i & (sel_commit | sel_mis))
          state_n = e_fence;
      e_fence:
        if (fence_done_i & ~commit_v_r)
          state_n = e_run;
      default: state_n = e_run;
    endcase
  end

  always_comb begin
    run      = (state_r == e_run);
    fenced_o = (state_r == e_fence);
  end

`ifdef BP_BE_FE_CMD_ARB_STATS_EN
  logic        drop;
  logic [15:0] drops_r;

  assign drop = ab_acc & fifo_full & ~pop;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)
      drops_r <= '0;
    else if (drop && drops_r != 16'hFFFF)
      drops_r <= drops_r + 16'd1;
  end

  assign attaboy_drops_o = drops_r;
`else
  assign attaboy_drops_o = '0;
`endif

  a_yumi_needs_v: assert property (
    @(posedge clk_i) disable iff (!reset_n_i)
    cmd_yumi_i |-> cmd_v_o);

endmodule

// File: tb/tb_bp_be_fe_cmd_arbiter.sv
// Directed vector bench for bp_be_fe_cmd_arbiter.
// Expected drop counts follow BP_BE_FE_CMD_ARB_STATS_EN.
module tb_bp_be_fe_cmd_arbiter;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        commit_v_i = 1'b0;
  logic [63:0] commit_cmd_i = '0;
  logic        spec_v_i = 1'b0;
  logic        spec_attaboy_i = 1'b0;
  logic [63:0] spec_cmd_i = '0;
  logic        spec_ready_o;
  logic [63:0] cmd_o;
  logic        cmd_v_o;
  logic        cmd_yumi_i = 1'b0;
  logic        fence_done_i = 1'b0;
  logic        fenced_o;
  logic        overflow_o;
  logic [15:0] attaboy_drops_o;

  always #5 clk_i = ~clk_i;

  bp_be_fe_cmd_arbiter #(
    .cmd_width_p(64),
    .attaboy_fifo_els_p(4)
  ) dut (
    .clk_i(clk_i),
    .reset_n_i(reset_n_i),
    .commit_v_i(commit_v_i),
    .commit_cmd_i(commit_cmd_i),
    .spec_v_i(spec_v_i),
    .spec_attaboy_i(spec_attaboy_i),
    .spec_cmd_i(spec_cmd_i),
    .spec_ready_o(spec_ready_o),
    .cmd_o(cmd_o),
    .cmd_v_o(cmd_v_o),
    .cmd_yumi_i(cmd_yumi_i),
    .fence_done_i(fence_done_i),
    .fenced_o(fenced_o),
    .overflow_o(overflow_o),
    .attaboy_drops_o(attaboy_drops_o)
  );

  typedef struct {
    logic        cv;
    logic [63:0] cc;
    logic        sv;
    logic        sab;
    logic [63:0] sc;
    logic        y;
    logic        fd;
    logic        ev;
    logic [63:0] ec;
    logic        er;
    logic        ef;
    logic        eo;
    logic [15:0] ed;
  } vec_t;

  vec_t vecs[$];
  int   n_run = 0;
  int   n_fail = 0;

  task automatic add(
    input logic cv, input logic [63:0] cc,
    input logic sv, input logic sab,
    input logic [63:0] sc,
    input logic y, input logic fd,
    input logic ev, input logic [63:0] ec,
    input logic er, input logic ef,
    input logic eo, input logic [15:0] ed);
    vec_t t;
    t.cv = cv; t.cc = cc; t.sv = sv;
    t.sab = sab; t.sc = sc; t.y = y;
    t.fd = fd; t.ev = ev; t.ec = ec;
    t.er = er; t.ef = ef; t.eo = eo;
    t.ed = ed;
    vecs.push_back(t);
  endtask

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  function automatic logic [15:0] drops(
    input logic [15:0] d);
`ifdef BP_BE_FE_CMD_ARB_STATS_EN
    return d;
`else
    return d & 16'h0;
`endif
  endfunction

  task automatic idle();
    commit_v_i = 0; spec_v_i = 0;
    spec_attaboy_i = 0; cmd_yumi_i = 0;
    fence_done_i = 0;
  endtask

  initial begin
    // attaboy fill, drop on full, drain in order
    add(0,0, 1,1,'hA0, 0,0, 0,0,    1,0,0,0);
    add(0,0, 1,1,'hA1, 0,0, 1,'hA0, 1,0,0,0);
    add(0,0, 1,1,'hA2, 0,0, 1,'hA0, 1,0,0,0);
    add(0,0, 1,1,'hA3, 0,0, 1,'hA0, 1,0,0,0);
    add(0,0, 1,1,'hA4, 0,0, 1,'hA0, 1,0,0,0);
    add(0,0, 0,0,0,    1,0, 1,'hA0, 1,0,0,1);
    add(0,0, 0,0,0,    1,0, 1,'hA1, 1,0,0,1);
    add(0,0, 0,0,0,    1,0, 1,'hA2, 1,0,0,1);
    add(0,0, 0,0,0,    1,0, 1,'hA3, 1,0,0,1);
    add(0,0, 0,0,0,    0,0, 0,0,    1,0,0,1);
    // mispredict flushes FIFO, then fence
    add(0,0, 1,1,'hB0, 0,0, 0,0,    1,0,0,1);
    add(0,0, 1,1,'hB1, 0,0, 1,'hB0, 1,0,0,1);
    add(0,0, 1,0,'hE1, 0,0, 1,'hB0, 1,0,0,1);
    add(0,0, 0,0,0,    0,0, 1,'hE1, 0,0,0,1);
    add(0,0, 0,0,0,    1,0, 1,'hE1, 0,0,0,1);
    add(0,0, 0,0,0,    0,0, 0,0,    0,1,0,1);
    add(0,0, 0,0,0,    0,1, 0,0,    0,1,0,1);
    add(0,0, 0,0,0,    0,0, 0,0,    1,0,0,1);
    // commit squashes held mispredict
    add(0,0,     1,0,'hE2, 0,0, 0,0,    1,0,0,1);
    add(1,'hC1,  0,0,0,    0,0, 1,'hE2, 0,0,0,1);
    add(0,0,     0,0,0,    0,0, 1,'hC1, 0,0,0,1);
    add(0,0,     0,0,0,    1,0, 1,'hC1, 0,0,0,1);
    add(0,0,     0,0,0,    0,1, 0,0,    0,1,0,1);
    add(0,0,     0,0,0,    0,0, 0,0,    1,0,0,1);
    // commit overwrite sets sticky overflow
    add(1,'hC2,  0,0,0,    0,0, 0,0,    0,0,0,1);
    add(1,'hC3,  0,0,0,    0,0, 1,'hC2, 0,0,0,1);
    add(0,0,     0,0,0,    1,0, 1,'hC3, 0,0,1,1);
    add(0,0,     0,0,0,    0,0, 0,0,    0,1,1,1);
    // commits issued while fenced
    add(1,'hC4,  0,0,0,    0,0, 0,0,    0,1,1,1);
    add(0,0,     0,0,0,    1,0, 1,'hC4, 0,1,1,1);
    add(0,0,     0,0,0,    0,0, 0,0,    0,1,1,1);
    add(1,'hC5,  0,0,0,    0,0, 0,0,    0,1,1,1);
    add(0,0,     0,0,0,    0,1, 1,'hC5, 0,1,1,1);
    add(0,0,     0,0,0,    0,0, 1,'hC5, 0,1,1,1);
    add(0,0,     0,0,0,    1,0, 1,'hC5, 0,1,1,1);
    add(0,0,     0,0,0,    0,1, 0,0,    0,1,1,1);
    add(0,0,     0,0,0,    0,0, 0,0,    1,0,1,1);
    // write into full FIFO with same-cycle pop
    add(0,0, 1,1,'hD0, 0,0, 0,0,    1,0,1,1);
    add(0,0, 1,1,'hD1, 0,0, 1,'hD0, 1,0,1,1);
    add(0,0, 1,1,'hD2, 0,0, 1,'hD0, 1,0,1,1);
    add(0,0, 1,1,'hD3, 0,0, 1,'hD0, 1,0,1,1);
    add(0,0, 1,1,'hD4, 1,0, 1,'hD0, 1,0,1,1);
    add(0,0, 0,0,0,    1,0, 1,'hD1, 1,0,1,1);
    add(0,0, 0,0,0,    1,0, 1,'hD2, 1,0,1,1);
    add(0,0, 0,0,0,    1,0, 1,'hD3, 1,0,1,1);
    add(0,0, 0,0,0,    1,0, 1,'hD4, 1,0,1,1);
    add(0,0, 0,0,0,    0,0, 0,0,    1,0,1,1);

    // reset state, with a spec request pending
    spec_v_i = 1; spec_attaboy_i = 1;
    #2;
    chk("rst_cmd_v", 64'(cmd_v_o), 0);
    chk("rst_ready", 64'(spec_ready_o), 0);
    chk("rst_fenced", 64'(fenced_o), 0);
    chk("rst_ovf", 64'(overflow_o), 0);
    chk("rst_drops", 64'(attaboy_drops_o), 0);
    idle();
    @(negedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1;

    foreach (vecs[i]) begin
      @(negedge clk_i);
      commit_v_i     = vecs[i].cv;
      commit_cmd_i   = vecs[i].cc;
      spec_v_i       = vecs[i].sv;
      spec_attaboy_i = vecs[i].sab;
      spec_cmd_i     = vecs[i].sc;
      cmd_yumi_i     = vecs[i].y;
      fence_done_i   = vecs[i].fd;
      #1;
      chk($sformatf("v%0d_cmd_v", i),
          64'(cmd_v_o), 64'(vecs[i].ev));
      if (vecs[i].ev)
        chk($sformatf("v%0d_cmd", i),
            cmd_o, vecs[i].ec);
      chk($sformatf("v%0d_ready", i),
          64'(spec_ready_o), 64'(vecs[i].er));
      chk($sformatf("v%0d_fenced", i),
          64'(fenced_o), 64'(vecs[i].ef));
      chk($sformatf("v%0d_ovf", i),
          64'(overflow_o), 64'(vecs[i].eo));
      chk($sformatf("v%0d_drops", i),
          64'(attaboy_drops_o),
          64'(drops(vecs[i].ed)));
    end

    // mid-stream async reset with three queued attaboys
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      idle();
      spec_v_i = 1; spec_attaboy_i = 1;
      spec_cmd_i = 64'h50 + 64'(k);
    end
    @(negedge clk_i);
    idle();
    #1;
    chk("pre_rst_cmd_v", 64'(cmd_v_o), 1);
    chk("pre_rst_cmd", cmd_o, 64'h50);
    #1 reset_n_i = 0;
    #1;
    chk("async_cmd_v", 64'(cmd_v_o), 0);
    chk("async_ready", 64'(spec_ready_o), 0);
    chk("async_ovf", 64'(overflow_o), 0);
    chk("async_drops", 64'(attaboy_drops_o), 0);
    @(negedge clk_i);
    reset_n_i = 1;
    #1;
    chk("post_cmd_v", 64'(cmd_v_o), 0);
    chk("post_ready", 64'(spec_ready_o), 1);
    chk("post_fenced", 64'(fenced_o), 0);
    chk("post_ovf", 64'(overflow_o), 0);
    spec_v_i = 1; spec_attaboy_i = 1;
    spec_cmd_i = 64'h60;
    @(negedge clk_i);
    idle();
    #1;
    chk("post_push_v", 64'(cmd_v_o), 1);
    chk("post_push_cmd", cmd_o, 64'h60);
    cmd_yumi_i = 1;
    @(negedge clk_i);
    idle();
    #1;
    chk("post_pop_v", 64'(cmd_v_o), 0);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
